// File: rtl/fifo_arb_pkg.sv
// Shared constants for the FIFO write-port arbiter.
// State encoding is kept as plain localparam constants so older blocks
// that compare raw state bits keep working.
package fifo_arb_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    // Width of the optional FIFO-full stall counter.
    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request found
// when scanning cyclically from ptr+1, as a one-hot vector and an index.
// Kept free of arbiter state so other arbiters can reuse it.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    // Scan N candidates starting one past the last owner; first hit wins.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int off = 1; off <= N; off++) begin
            cand = IDX_W'((int'(ptr) + off) % N);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// One owner at a time gets a burst of up to MAX_BURST words; FIFO full
// stalls the burst without releasing it. Acceptance is zero-latency:
// wr_en_o/ack_o/wdata_o are combinational from registered state + req/full.
// busy_o is the FSM state bit (BURST=1) and doubles as its debug view.
//
// Handshake: a word of requester k transfers in any cycle where
// ack_o[k]=1 (equivalently wr_en_o=1 with gnt_o[k]=1). The producer keeps
// req_i[k] and its word stable until it sees ack_o[k].
//
// Optional build macro FIFO_WR_ARB_STALL_CNT_EN adds stall_cnt_o, a
// saturating count of cycles the owner was blocked by FIFO full.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*WIDTH-1:0] wdata_i,
    input  logic                     full_i,
    output logic [NUM_REQ-1:0]       ack_o,
    output logic [NUM_REQ-1:0]       gnt_o,
    output logic                     wr_en_o,
    output logic [WIDTH-1:0]         wdata_o,
    output logic                     busy_o
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0]   stall_cnt_o
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [0:0]         state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [PTR_W-1:0]   ptr_q;    // last owner; equals current owner in BURST
    logic [CNT_W-1:0]   cnt_q;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_any;

    logic [WIDTH-1:0]   words [NUM_REQ];
    logic               in_burst;
    logic               owner_req;
    logic               accept;
    logic               last_word;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (PTR_W)
    ) u_pick (
        .req (req_i),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Unpack the per-requester words so the owner's word is a simple select.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            words[k] = wdata_i[k*WIDTH +: WIDTH];
        end
    end

    // Acceptance decode. Reset suppresses the write so an abandoned burst
    // never pushes a word on the reset edge.
    always_comb begin
        in_burst  = (state_q == ST_BURST);
        owner_req = req_i[ptr_q];
        accept    = in_burst & owner_req & ~full_i & ~rst_i;
        last_word = (cnt_q == CNT_W'(MAX_BURST - 1));
    end

    assign wr_en_o = accept;
    assign ack_o   = accept ? gnt_q : '0;
    assign wdata_o = accept ? words[ptr_q] : '0;
    assign gnt_o   = gnt_q;
    assign busy_o  = in_burst;

    // Arbitration FSM: IDLE picks an owner (one-cycle bubble), BURST
    // streams words until the burst limit or the owner drops its request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            ptr_q   <= PTR_W'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        state_q <= ST_BURST;
                        gnt_q   <= pick_gnt;
                        ptr_q   <= pick_idx;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    if (!owner_req) begin
                        state_q <= ST_IDLE;
                        gnt_q   <= '0;
                    end else if (!full_i) begin
                        if (last_word) begin
                            state_q <= ST_IDLE;
                            gnt_q   <= '0;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_q;

    // Count owner cycles blocked by FIFO full, saturating at all-ones.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else if (in_burst && owner_req && full_i && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter (NUM_REQ=4, WIDTH=8, MAX_BURST=4):
// a vector table for the directed scenarios, hand-written round-robin and
// reset-mid-burst sequences, then randomized traffic against a model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic           clk_i;
    logic           rst_i;
    logic [N-1:0]   req_i;
    logic [N*W-1:0] wdata_i;
    logic           full_i;
    logic [N-1:0]   ack_o;
    logic [N-1:0]   gnt_o;
    logic           wr_en_o;
    logic [W-1:0]   wdata_o;
    logic           busy_o;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    logic [15:0]    stall_cnt_o;
`endif

    int n_total = 0;
    int n_pass  = 0;

    fifo_wr_arbiter #(
        .NUM_REQ   (N),
        .WIDTH     (W),
        .MAX_BURST (MB)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .wdata_i (wdata_i),
        .full_i  (full_i),
        .ack_o   (ack_o),
        .gnt_o   (gnt_o),
        .wr_en_o (wr_en_o),
        .wdata_o (wdata_o),
        .busy_o  (busy_o)
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    // Clock and watchdog.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic         full;
        logic [N-1:0] gnt;
        logic         wr;
        logic [N-1:0] ack;
        logic         busy;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic [N-1:0] rq, input logic f,
                       input logic [N-1:0] g, input logic w,
                       input logic [N-1:0] a, input logic b);
        vec_t v;
        v.rst = r; v.req = rq; v.full = f; v.gnt = g; v.wr = w; v.ack = a; v.busy = b;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [W-1:0] word_of(input logic [N*W-1:0] d, input int k);
        return W'(d >> (k * W));
    endfunction

    function automatic logic bit_of(input logic [N-1:0] v, input int k);
        return 1'((v >> k) & 1);
    endfunction

    // Reference model state: owner as an integer, -1 meaning no owner.
    int m_owner, m_last, m_cnt, m_stall;

    initial begin
        vec_t v;
        logic [W-1:0] ew;
        logic         acc;
        int           w_win;

        rst_i = 1'b1; req_i = '0; full_i = 1'b0;
        wdata_i = {8'h44, 8'h33, 8'h22, 8'h11};
        step();

        // Reset held with all requests; first grant goes to requester 0.
        add(1, 4'hF, 0, 4'h0, 0, 4'h0, 0);
        add(1, 4'hF, 0, 4'h0, 0, 4'h0, 0);
        add(0, 4'hF, 0, 4'h0, 0, 4'h0, 0);
        add(0, 4'hF, 0, 4'h1, 1, 4'h1, 1);
        add(0, 4'h0, 0, 4'h1, 0, 4'h0, 1);
        add(0, 4'h0, 0, 4'h0, 0, 4'h0, 0);
        // Single requester 2 for 6 words: burst of 4, bubble, 2 more.
        add(0, 4'h4, 0, 4'h0, 0, 4'h0, 0);
        for (int i = 0; i < 4; i++) add(0, 4'h4, 0, 4'h4, 1, 4'h4, 1);
        add(0, 4'h4, 0, 4'h0, 0, 4'h0, 0);
        for (int i = 0; i < 2; i++) add(0, 4'h4, 0, 4'h4, 1, 4'h4, 1);
        add(0, 4'h0, 0, 4'h4, 0, 4'h0, 1);
        add(0, 4'h0, 0, 4'h0, 0, 4'h0, 0);
        // Owner 1: two words, three full cycles, two more words.
        add(0, 4'h2, 0, 4'h0, 0, 4'h0, 0);
        for (int i = 0; i < 2; i++) add(0, 4'h2, 0, 4'h2, 1, 4'h2, 1);
        for (int i = 0; i < 3; i++) add(0, 4'h2, 1, 4'h2, 0, 4'h0, 1);
        for (int i = 0; i < 2; i++) add(0, 4'h2, 0, 4'h2, 1, 4'h2, 1);
        add(0, 4'h0, 0, 4'h0, 0, 4'h0, 0);
        // Owner 3 drops after one word; next search starts at requester 0.
        add(0, 4'h8, 0, 4'h0, 0, 4'h0, 0);
        add(0, 4'h8, 0, 4'h8, 1, 4'h8, 1);
        add(0, 4'h0, 0, 4'h8, 0, 4'h0, 1);
        add(0, 4'hF, 0, 4'h0, 0, 4'h0, 0);
        add(0, 4'h0, 0, 4'h1, 0, 4'h0, 1);
        add(0, 4'h0, 0, 4'h0, 0, 4'h0, 0);

        foreach (vq[i]) begin
            v = vq[i];
            rst_i = v.rst; req_i = v.req; full_i = v.full;
            #1;
            ew = '0;
            for (int k = 0; k < N; k++) if (bit_of(v.ack, k)) ew = word_of(wdata_i, k);
            check($sformatf("vec%0d gnt", i), 32'(gnt_o), 32'(v.gnt));
            check($sformatf("vec%0d wr_en", i), 32'(wr_en_o), 32'(v.wr));
            check($sformatf("vec%0d ack", i), 32'(ack_o), 32'(v.ack));
            check($sformatf("vec%0d busy", i), 32'(busy_o), 32'(v.busy));
            check($sformatf("vec%0d wdata", i), 32'(wdata_o), 32'(ew));
            step();
        end
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        check("stall_cnt after full stall", 32'(stall_cnt_o), 32'd3);
`endif

        // Round-robin with all four requesting: order 0,1,2,3,0.
        rst_i = 1'b1; req_i = '0; full_i = 1'b0;
        step();
        rst_i = 1'b0;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        check("stall_cnt after reset", 32'(stall_cnt_o), 32'd0);
`endif
        req_i = 4'hF;
        for (int b = 0; b < 5; b++) begin
            #1;
            check($sformatf("rr%0d bubble gnt", b), 32'(gnt_o), 32'd0);
            check($sformatf("rr%0d bubble wr_en", b), 32'(wr_en_o), 32'd0);
            step();
            for (int w = 0; w < MB; w++) begin
                #1;
                check($sformatf("rr%0d.%0d gnt", b, w), 32'(gnt_o), 32'(1 << (b % N)));
                check($sformatf("rr%0d.%0d ack", b, w), 32'(ack_o), 32'(1 << (b % N)));
                check($sformatf("rr%0d.%0d wr_en", b, w), 32'(wr_en_o), 32'd1);
                check($sformatf("rr%0d.%0d wdata", b, w), 32'(wdata_o), 32'(word_of(wdata_i, b % N)));
                step();
            end
        end

        // Reset mid-burst: owner 1 after two words.
        #1;
        check("mid idle gnt", 32'(gnt_o), 32'd0);
        step();
        for (int w = 0; w < 2; w++) begin
            #1;
            check($sformatf("mid w%0d ack", w), 32'(ack_o), 32'h2);
            step();
        end
        rst_i = 1'b1;
        #1;
        check("mid rst wr_en", 32'(wr_en_o), 32'd0);
        check("mid rst ack", 32'(ack_o), 32'd0);
        check("mid rst wdata", 32'(wdata_o), 32'd0);
        step();
        rst_i = 1'b0;
        #1;
        check("post rst gnt", 32'(gnt_o), 32'd0);
        check("post rst wr_en", 32'(wr_en_o), 32'd0);
        check("post rst busy", 32'(busy_o), 32'd0);
        step();
        #1;
        check("post rst regrant", 32'(gnt_o), 32'h1);
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        check("post rst stall_cnt", 32'(stall_cnt_o), 32'd0);
`endif

        // Randomized traffic against the reference model.
        rst_i = 1'b1; req_i = '0; full_i = 1'b0;
        step();
        rst_i = 1'b0;
        m_owner = -1; m_last = N - 1; m_cnt = 0; m_stall = 0;
        for (int c = 0; c < 600; c++) begin
            rst_i = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 3) == 0) req_i = N'($urandom_range(0, 15));
            full_i  = ($urandom_range(0, 3) == 0);
            wdata_i = $urandom;
            #1;
            acc = !rst_i && (m_owner >= 0) && bit_of(req_i, m_owner) && !full_i;
            check($sformatf("rnd%0d gnt", c), 32'(gnt_o), (m_owner >= 0) ? 32'(1 << m_owner) : 32'd0);
            check($sformatf("rnd%0d busy", c), 32'(busy_o), 32'(m_owner >= 0));
            check($sformatf("rnd%0d wr_en", c), 32'(wr_en_o), 32'(acc));
            check($sformatf("rnd%0d ack", c), 32'(ack_o), acc ? 32'(1 << m_owner) : 32'd0);
            check($sformatf("rnd%0d wdata", c), 32'(wdata_o), acc ? 32'(word_of(wdata_i, m_owner)) : 32'd0);
            check($sformatf("rnd%0d wr_while_full", c), 32'(wr_en_o & full_i), 32'd0);
`ifdef FIFO_WR_ARB_STALL_CNT_EN
            check($sformatf("rnd%0d stall_cnt", c), 32'(stall_cnt_o), 32'(m_stall));
`endif
            if (rst_i) begin
                m_owner = -1; m_last = N - 1; m_cnt = 0; m_stall = 0;
            end else if (m_owner < 0) begin
                w_win = -1;
                for (int off = 1; off <= N; off++)
                    if (w_win < 0 && bit_of(req_i, (m_last + off) % N)) w_win = (m_last + off) % N;
                if (w_win >= 0) begin
                    m_owner = w_win; m_last = w_win; m_cnt = 0;
                end
            end else if (!bit_of(req_i, m_owner)) begin
                m_owner = -1;
            end else if (full_i) begin
                if (m_stall < 65535) m_stall++;
            end else begin
                m_cnt++;
                if (m_cnt == MB) m_owner = -1;
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
